// File: rtl/iob_axi_mem_slave.sv
// iob_axi_mem_slave: AXI4 responder backed by a dual-port word RAM.
// Define AXI_MEM_BP_EN to add LFSR-driven random AW/W/AR backpressure.
module iob_axi_mem_slave #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic                  s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic                  s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic                  s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int NB    = DATA_W / 8;
    localparam int BL    = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic stall;
`ifdef AXI_MEM_BP_EN
    logic [15:0] lfsr;

    // Free-running LFSR; its two low bits select stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Upper and sub-word address bits alias and are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    wstate_t               wstate;
    logic                  aw_rdy;
    logic                  w_rdy;
    logic [MEM_ADDR_W-1:0] waddr;
    logic [7:0]            wlen;
    logic [1:0]            wburst;
    logic [8:0]            wcnt;
    logic                  werr;

    logic w_hs;
    logic w_over;
    logic w_bad_last;
    logic mem_we;

    assign s_axi_awready = aw_rdy & ~stall;
    assign s_axi_wready  = w_rdy & ~stall;

    assign w_hs       = s_axi_wvalid & s_axi_wready;
    assign w_over     = wcnt > {1'b0, wlen};
    assign w_bad_last = s_axi_wlast & (wcnt != {1'b0, wlen});
    assign mem_we     = w_hs & ~w_over & (wburst != 2'b11);

    // Write channel: accept AW, stream W beats, then hold B until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate       <= W_IDLE;
            aw_rdy       <= 1'b1;
            w_rdy        <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_bid    <= 1'b0;
            waddr        <= '0;
            wlen         <= '0;
            wburst       <= '0;
            wcnt         <= '0;
            werr         <= 1'b0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_bid <= s_axi_awid;
                        waddr     <= s_axi_awaddr[MEM_ADDR_W+BL-1:BL];
                        wlen      <= s_axi_awlen;
                        wburst    <= s_axi_awburst;
                        wcnt      <= '0;
                        werr      <= 1'b0;
                        aw_rdy    <= 1'b0;
                        w_rdy     <= 1'b1;
                        wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wburst != 2'b00) begin
                            waddr <= waddr + MEM_ADDR_W'(1);
                        end
                        if (wcnt != '1) begin
                            wcnt <= wcnt + 9'd1;
                        end
                        if (w_over || w_bad_last) begin
                            werr <= 1'b1;
                        end
                        if (s_axi_wlast) begin
                            w_rdy        <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (werr || w_over || w_bad_last ||
                                             wburst == 2'b11) ? 2'b10 : 2'b00;
                            wstate       <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        aw_rdy       <= 1'b1;
                        wstate       <= W_IDLE;
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM write port driven by the write channel.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    rstate_t               rstate;
    logic                  ar_rdy;
    logic [MEM_ADDR_W-1:0] raddr;
    logic [MEM_ADDR_W-1:0] r_next;
    logic [MEM_ADDR_W-1:0] ar_word;
    logic [7:0]            rlen;
    logic [7:0]            rcnt;
    logic [1:0]            rburst;
    logic                  r_hs;

    assign s_axi_arready = ar_rdy & ~stall;
    assign ar_word       = s_axi_araddr[MEM_ADDR_W+BL-1:BL];
    assign r_next        = (rburst == 2'b00) ? raddr : raddr + MEM_ADDR_W'(1);
    assign r_hs          = s_axi_rvalid & s_axi_rready;

    // Read channel: prefetch one word per accepted beat, hold data on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate       <= R_IDLE;
            ar_rdy       <= 1'b1;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rid    <= 1'b0;
            s_axi_rdata  <= '0;
            raddr        <= '0;
            rlen         <= '0;
            rcnt         <= '0;
            rburst       <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rid    <= s_axi_arid;
                        raddr        <= ar_word;
                        rlen         <= s_axi_arlen;
                        rburst       <= s_axi_arburst;
                        rcnt         <= '0;
                        s_axi_rdata  <= (s_axi_arburst == 2'b11) ? '0 : mem[ar_word];
                        s_axi_rresp  <= (s_axi_arburst == 2'b11) ? 2'b10 : 2'b00;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rlast  <= (s_axi_arlen == 8'd0);
                        ar_rdy       <= 1'b0;
                        rstate       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid <= 1'b0;
                            s_axi_rlast  <= 1'b0;
                            ar_rdy       <= 1'b1;
                            rstate       <= R_IDLE;
                        end else begin
                            raddr       <= r_next;
                            rcnt        <= rcnt + 8'd1;
                            s_axi_rdata <= (rburst == 2'b11) ? '0 : mem[r_next];
                            s_axi_rlast <= (rcnt + 8'd1 == rlen);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_axi_mem_slave.sv
// Bench for iob_axi_mem_slave: directed bursts checked against a
// word-array memory model with expected R-beat and B-response queues.
module tb_iob_axi_mem_slave;
    localparam int AW = 30;
    localparam int MW = 12;
    localparam int NW = 1 << MW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        awid = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        arid = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    iob_axi_mem_slave #(.ADDR_W(AW), .DATA_W(32), .MEM_ADDR_W(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [1:0]  r;
        logic        id;
    } rbeat_t;

    typedef struct {
        logic [1:0] r;
        logic       id;
    } bexp_t;

    logic [31:0] mm [NW];
    rbeat_t      rq[$];
    bexp_t       bq[$];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_got [16];
    int          r_beats;
    int          aw_hs_c, ar_hs_c, b_c, r_first_c, r_last_c;
    logic [1:0]  b_got;
    bit          rd_stall = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a[MW+1:2]);
    endfunction

    task automatic model_wr(input logic id, input logic [AW-1:0] a, input int len,
                            input logic [1:0] bt, input int nb);
        int idx;
        bit err;
        idx = widx(a);
        err = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b > len) err = 1'b1;
            else if (bt != 2'b11) begin
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) mm[idx][k*8 +: 8] = wd[b][k*8 +: 8];
            end
            if (b == nb - 1 && b != len) err = 1'b1;
            if (bt != 2'b00) idx = (idx + 1) % NW;
        end
        bq.push_back('{r: (err || bt == 2'b11) ? 2'b10 : 2'b00, id: id});
    endtask

    task automatic model_rd(input logic id, input logic [AW-1:0] a, input int len,
                            input logic [1:0] bt);
        int idx;
        idx = widx(a);
        for (int b = 0; b <= len; b++) begin
            rq.push_back('{d: (bt == 2'b11) ? 32'h0 : mm[idx], l: (b == len),
                           r: (bt == 2'b11) ? 2'b10 : 2'b00, id: id});
            if (bt != 2'b00) idx = (idx + 1) % NW;
        end
    endtask

    task automatic drv_aw(input logic id, input logic [AW-1:0] a, input int len,
                          input logic [1:0] bt);
        bit ok;
        awid = id; awaddr = a; awlen = 8'(len); awburst = bt; awvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = awready;
            if (ok) aw_hs_c = cyc;
        end
        if (!ok) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic drv_w(input int nb);
        bit ok;
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk);
                ok = wready;
            end
            if (!ok) chk("w_timeout", 0, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        bit seen, ok;
        seen = 1'b0; ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (bvalid && !seen) begin
                seen = 1'b1; b_c = cyc; b_got = bresp;
            end
            ok = bvalid && bready;
        end
        if (!ok) chk("b_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drv_ar(input logic id, input logic [AW-1:0] a, input int len,
                          input logic [1:0] bt);
        bit ok;
        arid = id; araddr = a; arlen = 8'(len); arburst = bt; arvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = arready;
            if (ok) ar_hs_c = cyc;
        end
        if (!ok) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drv_r();
        bit done;
        int bi;
        done = 1'b0; bi = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            rready = rd_stall ? (t % 3 == 0) : 1'b1;
            @(negedge clk);
            if (rvalid && rready) begin
                if (bi < 16) rd_got[bi] = rdata;
                if (bi == 0) r_first_c = cyc;
                if (rlast) begin
                    r_last_c = cyc; done = 1'b1;
                end
                bi++;
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (!done) chk("r_timeout", 0, 1);
        r_beats = bi;
    endtask

    task automatic wr(input logic id, input logic [AW-1:0] a, input int len,
                      input logic [1:0] bt, input int nb);
        model_wr(id, a, len, bt, nb);
        drv_aw(id, a, len, bt);
        drv_w(nb);
        wait_b();
    endtask

    task automatic rd(input logic id, input logic [AW-1:0] a, input int len,
                      input logic [1:0] bt);
        model_rd(id, a, len, bt);
        drv_ar(id, a, len, bt);
        drv_r();
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = 4'hF;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_awready"}, awready, 1);
        chk({tag, "_arready"}, arready, 1);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rlast"}, rlast, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_bid"}, bid, 0);
        chk({tag, "_rid"}, rid, 0);
    endtask

    // Every-cycle compare of the R and B channels against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    chk("rdata", rdata, rq[0].d);
                    chk("rlast", rlast, rq[0].l);
                    chk("rresp", rresp, rq[0].r);
                    chk("rid", rid, rq[0].id);
                    if (rready) void'(rq.pop_front());
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    chk("bresp", bresp, bq[0].r);
                    chk("bid", bid, bq[0].id);
                    if (bready) void'(bq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            wd[i] = '0; ws[i] = 4'hF; rd_got[i] = '0;
        end
        #2 rst_n = 1'b0;
        #2 chk_reset("rst");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr(1'b1, 30'h10, 0, 2'b01, 1);
        chk("single_b_latency", b_c, aw_hs_c + 2);
        chk("single_bresp", b_got, 2'b00);
        rd(1'b1, 30'h10, 0, 2'b01);
        chk("single_rdata", rd_got[0], 32'hDEADBEEF);
        chk("single_beats", r_beats, 1);
        rd(1'b0, 30'h4010, 0, 2'b01);
        chk("alias_rdata", rd_got[0], 32'hDEADBEEF);

        fill(32'h0, 8);
        wr(1'b0, 30'h100, 7, 2'b01, 8);
        chk("incr_bresp", b_got, 2'b00);
        rd(1'b1, 30'h100, 7, 2'b01);
        chk("incr_first_lat", r_first_c, ar_hs_c + 1);
        chk("incr_span", r_last_c - r_first_c, 7);
        chk("incr_beats", r_beats, 8);
        for (int i = 0; i < 8; i++) chk("incr_data", rd_got[i], 32'(i));

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr(1'b0, 30'h20, 0, 2'b01, 1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        wr(1'b0, 30'h20, 0, 2'b01, 1);
        ws[0] = 4'hF;
        rd(1'b0, 30'h20, 0, 2'b01);
        chk("strb_merge", rd_got[0], 32'h11BB33DD);

        fill(32'h50, 4);
        wr(1'b0, 30'h200, 3, 2'b01, 4);
        wd[0] = 32'hA0; wd[1] = 32'hA1;
        wr(1'b1, 30'h200, 3, 2'b01, 2);
        chk("early_wlast_bresp", b_got, 2'b10);
        rd(1'b0, 30'h200, 3, 2'b01);
        chk("early_w0", rd_got[0], 32'hA0);
        chk("early_w1", rd_got[1], 32'hA1);
        chk("early_w2", rd_got[2], 32'h52);
        chk("early_w3", rd_got[3], 32'h53);

        wd[0] = 32'hFFFFFFFF;
        wr(1'b1, 30'h200, 0, 2'b11, 1);
        chk("rsvd_bresp", b_got, 2'b10);
        rd(1'b0, 30'h200, 0, 2'b01);
        chk("rsvd_unchanged", rd_got[0], 32'hA0);

        fill(32'h60, 2);
        wr(1'b0, 30'h300, 1, 2'b01, 2);
        wd[0] = 32'h70; wd[1] = 32'h71;
        wr(1'b0, 30'h300, 0, 2'b01, 2);
        chk("excess_bresp", b_got, 2'b10);
        rd(1'b0, 30'h300, 1, 2'b01);
        chk("excess_w0", rd_got[0], 32'h70);
        chk("excess_w1", rd_got[1], 32'h61);

        fill(32'h1, 3);
        wr(1'b0, 30'h400, 2, 2'b00, 3);
        rd(1'b0, 30'h400, 1, 2'b00);
        chk("fixed_r0", rd_got[0], 32'h3);
        chk("fixed_r1", rd_got[1], 32'h3);

        fill(32'hC0, 4);
        wr(1'b0, 30'h3FFC, 3, 2'b01, 4);
        rd_stall = 1'b1;
        rd(1'b1, 30'h3FFC, 3, 2'b01);
        rd_stall = 1'b0;
        for (int i = 0; i < 4; i++) chk("wrap_data", rd_got[i], 32'hC0 + 32'(i));

        rd(1'b0, 30'h100, 1, 2'b11);
        chk("rsvd_r_beats", r_beats, 2);
        chk("rsvd_r_data", rd_got[1], 32'h0);

        wd[0] = 32'h12345678; ws[0] = 4'hF;
        model_rd(1'b0, 30'h10, 0, 2'b01);
        model_wr(1'b1, 30'h10, 0, 2'b01, 1);
        fork
            begin
                drv_aw(1'b1, 30'h10, 0, 2'b01);
                drv_w(1);
                wait_b();
            end
            begin
                @(posedge clk); #1;
                drv_ar(1'b0, 30'h10, 0, 2'b01);
                drv_r();
            end
        join
        chk("concur_same_edge", ar_hs_c, aw_hs_c + 1);
        chk("concur_old", rd_got[0], 32'hDEADBEEF);
        chk("concur_bresp", b_got, 2'b00);
        rd(1'b0, 30'h10, 0, 2'b01);
        chk("concur_new", rd_got[0], 32'h12345678);

        model_rd(1'b1, 30'h100, 7, 2'b01);
        drv_ar(1'b1, 30'h100, 7, 2'b01);
        rready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        rq.delete();
        bq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b0;
        @(posedge clk); #1;

        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        wr(1'b0, 30'h10, 0, 2'b01, 1);
        rd(1'b1, 30'h10, 0, 2'b01);
        chk("post_rst_rdata", rd_got[0], 32'h0BADF00D);

        repeat (3) @(posedge clk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_axi_mem_slave.md
Name: iob_axi_mem_slave

Overview:
Synthesizable AXI4 responder that terminates the system's DDR master port (m_axi_*). It stands in for the memory controller in simulation and in FPGA builds without DDR. It holds a dual-port word RAM and supports INCR and FIXED bursts with independent read and write channel state machines.

Parameters:
ADDR_W, 30, AXI byte-address width (matches DDR_ADDR_W).
DATA_W, 32, AXI data width (matches MIG_BUS_W); byte-lane count is DATA_W/8.
MEM_ADDR_W, 12, log2 of RAM depth in DATA_W words.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axi_awid  in  1  write ID
s_axi_awaddr  in  ADDR_W  write burst start byte address
s_axi_awlen  in  8  beats minus one
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awvalid / s_axi_awready  in / out  1 / 1  AW handshake
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in / out  1 / 1  W handshake
s_axi_bid  out  1  echoed awid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid / s_axi_bready  out / in  1 / 1  B handshake
s_axi_arid  in  1  read ID
s_axi_araddr  in  ADDR_W  read burst start byte address
s_axi_arlen  in  8  beats minus one
s_axi_arburst  in  2  burst type
s_axi_arvalid / s_axi_arready  in / out  1 / 1  AR handshake
s_axi_rid  out  1  echoed arid
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out / in  1 / 1  R handshake

Behaviour:
- Size, lock, cache, prot and qos are not ported. Every beat is full width. Word index = addr[MEM_ADDR_W+log2(DATA_W/8)-1:log2(DATA_W/8)]; upper address bits alias.
- Reset (rst_n low, async): both FSMs go to IDLE. awready=1, arready=1. wready, bvalid, rvalid, rlast = 0. bresp, rresp, bid, rid, rdata = 0.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id, word address, len and burst; clear the beat counter and error flag; go to W_DATA.
  - W_DATA (wready=1): on each W handshake, write enabled bytes per wstrb. INCR advances the address by 1 word; FIXED holds it.
  - The word address wraps modulo 2^MEM_ADDR_W.
  - Beats beyond awlen+1 are accepted but not written, and set the error flag.
  - wlast on a beat other than number awlen+1 sets the error flag. That beat ends the burst.
  - The handshake beat carrying wlast moves the FSM to W_RESP.
  - W_RESP (bvalid=1): bresp = SLVERR if the error flag is set or burst==11, otherwise OKAY. When bready is high, go to W_IDLE, with awready high the next cycle.
- Write throughput: 1 beat/cycle. Minimum AW-to-B latency is 2 cycles for a single-beat burst.
- WRAP (10) is executed as INCR with OKAY response. Reserved (11) writes no data and returns SLVERR.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, issue the RAM read of the start word; go to R_DATA.
  - R_DATA: rvalid=1 the cycle after the AR handshake, and rlast=1 on beat arlen+1.
  - RAM read enable = (rvalid & rready & ~rlast). rdata holds stable while rvalid & ~rready.
  - The R handshake with rlast returns the FSM to R_IDLE, with arready high the next cycle.
  - Reserved burst type returns arlen+1 beats of rdata=0 with rresp=SLVERR.
- Read throughput: 1 beat/cycle.
- The two channels run concurrently.
- Same-word read and write in the same cycle: the read returns the old data (read-first).
- Reset asserted mid-burst aborts the burst. No B or R response is issued for the aborted burst. RAM contents are undefined after reset.

Optional Feature:
AXI_MEM_BP_EN:
- Defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle. awready, wready and arready are forced low whenever lfsr[1:0]==2'b00. This randomly backpressures the master for robustness testing; all other behaviour is unchanged.
- Undefined: the LFSR is absent and the ready signals behave exactly as specified above.

Test Plan:
- Single write: AW addr 0x10, len 0, INCR; W data 0xDEADBEEF, strb 0xF, wlast -> bvalid 2 cycles after AW handshake, bresp=00, bid matches; a read of 0x10 returns 0xDEADBEEF with rlast=1.
- INCR burst: write len 7 at 0x100 with data 0..7 -> OKAY; read len 7 with rready held high -> 8 beats in 8 consecutive cycles, data 0..7, rlast only on beat 8.
- Byte strobes: word 0x11223344, then write 0xAABBCCDD with strb 0x5 -> reads back 0x11BB33DD.
- Protocol errors: awlen=3 with wlast on beat 2 -> SLVERR, only 2 words written. awburst=11 -> SLVERR, memory unchanged.
- Read backpressure and wrap-around: read len 3 starting at the last word, with rready toggling 1,0,0,1 -> rdata is stable while stalled; beats 2-4 come from words 0-2.
- Concurrency: simultaneous AW/W and AR to the same word -> the read returns the old value and the write completes OKAY. Asserting rst_n=0 mid-read forces rvalid=0 asynchronously.
